// File: rtl/digit_serial_adder_if.sv
// Operand/result handshake bundle for the digit-serial adder.
interface digit_serial_adder_if #(
    parameter int WIDTH = 16
);
    localparam int CNT_W = $clog2(WIDTH / 4 + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic [CNT_W-1:0] skip_count;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, skip_count
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf, skip_count
    );
endinterface

// File: rtl/digit_serial_adder.sv
// Digit-serial WIDTH-bit adder: one 4-bit carry-skip slice reused per
// nibble, LSB nibble first, with a registered inter-nibble carry.
module digit_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    digit_serial_adder_if.slave bus
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int CNT_W   = $clog2(NIBBLES + 1);

    generate
        if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
            $error("digit_serial_adder: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
    logic             carry, a_msb, b_msb;
    logic [CNT_W-1:0] cnt, skip_cnt;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q, ovf_q;

    // slice signals
    logic [3:0]       p, g, s;
    logic [4:0]       c;
    logic             skip, slice_cout;
    logic [WIDTH-1:0] sum_next;
    logic             last;

    // Carry-skip slice: ripple inside the nibble, bypass when all bits propagate
    always_comb begin
        p    = a_sh[3:0] ^ b_sh[3:0];
        g    = a_sh[3:0] & b_sh[3:0];
        c    = '0;
        c[0] = carry;
        for (int i = 0; i < 4; i++)
            c[i+1] = g[i] | (p[i] & c[i]);
        s          = p ^ c[3:0];
        skip       = &p;
        slice_cout = skip ? carry : c[4];
        // new nibble enters at the MSB end; shift form also covers WIDTH=4
        sum_next   = (sum_sh >> 4) | (WIDTH'(s) << (WIDTH - 4));
        last       = (cnt == CNT_W'(NIBBLES - 1));
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nxt = RUN;
            RUN:     if (last)          state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
    end

    // Datapath: operand latch, nibble sequencing, result capture on last nibble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            sum_sh   <= '0;
            carry    <= 1'b0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            cnt      <= '0;
            skip_cnt <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    a_sh     <= bus.a;
                    b_sh     <= bus.b;
                    carry    <= bus.cin;
                    a_msb    <= bus.a[WIDTH-1];
                    b_msb    <= bus.b[WIDTH-1];
                    sum_sh   <= '0;
                    cnt      <= '0;
                    skip_cnt <= '0;
                end
                RUN: begin
                    sum_sh <= sum_next;
                    carry  <= slice_cout;
                    a_sh   <= a_sh >> 4;
                    b_sh   <= b_sh >> 4;
                    cnt    <= cnt + CNT_W'(1);
                    if (skip) skip_cnt <= skip_cnt + CNT_W'(1);
                    if (last) begin
                        sum_q  <= sum_next;
                        cout_q <= slice_cout;
                        ovf_q  <= (a_msb == b_msb) && (sum_next[WIDTH-1] != a_msb);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sum        = sum_q;
    assign bus.cout       = cout_q;
    assign bus.ovf        = ovf_q;
    assign bus.skip_count = skip_cnt;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Scoreboard bench for digit_serial_adder (WIDTH=16): the driver pushes
// hand-computed results on accept, a negedge monitor pops on handshake.
module tb_digit_serial_adder;
    localparam int WIDTH   = 16;
    localparam int NIBBLES = WIDTH / 4;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic [2:0]  skip;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    digit_serial_adder_if #(.WIDTH(WIDTH)) bus ();

    digit_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    // Monitor: any out_valid needs a pending expectation; compare on handshake
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_out_valid: got 1 want 0");
            end else if (bus.out_ready) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sum",        32'(bus.sum),        32'(e.sum));
                chk("cout",       32'(bus.cout),       32'(e.cout));
                chk("ovf",        32'(bus.ovf),        32'(e.ovf));
                chk("skip_count", 32'(bus.skip_count), 32'(e.skip));
            end
        end
    end

    // Drive one operand set; inputs change #1 after the rising edge
    task automatic send(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                        input exp_t e, input bit push, input bit wait_out);
        int n;
        bus.a        = ta;
        bus.b        = tb_;
        bus.cin      = tc;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk("in_ready_timeout", 32'(n), 32'(0));
        if (push) exp_q.push_back(e);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        if (wait_out) begin
            n = 0;
            while (!bus.out_valid && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            chk("latency_edges", 32'(n), 32'(NIBBLES));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   n;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        // reset state
        chk("rst_in_ready",  32'(bus.in_ready),   32'd1);
        chk("rst_out_valid", 32'(bus.out_valid),  32'd0);
        chk("rst_sum",       32'(bus.sum),        32'd0);
        chk("rst_cout",      32'(bus.cout),       32'd0);
        chk("rst_ovf",       32'(bus.ovf),        32'd0);
        chk("rst_skip",      32'(bus.skip_count), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // no nibble of 1234^4321 is all-ones, so nothing skips
        e = '{16'h5555, 1'b0, 1'b0, 3'd0}; send(16'h1234, 16'h4321, 1'b0, e, 1, 1);
        e = '{16'h0000, 1'b1, 1'b0, 3'd3}; send(16'hFFFF, 16'h0001, 1'b0, e, 1, 1);
        e = '{16'h8000, 1'b0, 1'b1, 3'd2}; send(16'h7FFF, 16'h0001, 1'b0, e, 1, 1);
        e = '{16'h0000, 1'b1, 1'b1, 3'd0}; send(16'h8000, 16'h8000, 1'b0, e, 1, 1);
        e = '{16'h0000, 1'b1, 1'b0, 3'd4}; send(16'hFFFF, 16'h0000, 1'b1, e, 1, 1);
        e = '{16'h0000, 1'b1, 1'b0, 3'd4}; send(16'hA5A5, 16'h5A5A, 1'b1, e, 1, 1);
        e = '{16'hFFFF, 1'b0, 1'b0, 3'd4}; send(16'hA5A5, 16'h5A5A, 1'b0, e, 1, 1);

        // backpressure: result held, new operands ignored while DONE
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        e = '{16'h3333, 1'b0, 1'b0, 3'd0}; send(16'h1111, 16'h2222, 1'b0, e, 1, 1);
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = i[0] ? 1'b0 : 1'b1;
            bus.a        = 16'hFFFF;
            bus.b        = 16'hFFFF;
            bus.cin      = 1'b1;
            @(negedge clk);
            chk("bp_out_valid", 32'(bus.out_valid),  32'd1);
            chk("bp_in_ready",  32'(bus.in_ready),   32'd0);
            chk("bp_sum",       32'(bus.sum),        32'h3333);
            chk("bp_cout",      32'(bus.cout),       32'd0);
            chk("bp_skip",      32'(bus.skip_count), 32'd0);
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_in_ready",  32'(bus.in_ready),  32'd1);
        chk("bp_release_out_valid", 32'(bus.out_valid), 32'd0);

        // reset during RUN: nothing is expected from the aborted transaction
        e = '{16'h0000, 1'b0, 1'b0, 3'd0}; send(16'h1234, 16'h1111, 1'b0, e, 0, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_in_ready",  32'(bus.in_ready),   32'd1);
        chk("abort_out_valid", 32'(bus.out_valid),  32'd0);
        chk("abort_sum",       32'(bus.sum),        32'd0);
        chk("abort_cout",      32'(bus.cout),       32'd0);
        chk("abort_ovf",       32'(bus.ovf),        32'd0);
        chk("abort_skip",      32'(bus.skip_count), 32'd0);
        repeat (8) @(posedge clk);
        #1;
        e = '{16'h0002, 1'b0, 1'b0, 3'd0}; send(16'h0001, 16'h0001, 1'b0, e, 1, 1);

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
